// File: rtl/word_asm_pkg.sv
// Shared types and width helpers for the byte-to-word assembler.
// Holds the FSM state encoding and byte_count / idle timer width functions.
package word_asm_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE    = 1'b0;
  localparam state_t COLLECT = 1'b1;

  // byte_count must also represent N itself
  function automatic int count_width(input int n);
    return $clog2(n) + 1;
  endfunction

  // timer counts 0 .. t-1 before expiring
  function automatic int timer_width(input int t);
    return (t < 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/word_asm_timeout.sv
// Idle timer for a partially assembled word.
// Ports: clk, rst_n, clear (restart), run (count this cycle), expired (comb).
module word_asm_timeout
  import word_asm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int TW = timer_width(TIMEOUT_CYCLES);
  localparam int LIMIT =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic ENABLE = (TIMEOUT_CYCLES > 0);

  logic [TW-1:0] count;

  // expires during the idle cycle that would be number TIMEOUT_CYCLES
  assign expired =
    ENABLE && run && (count == TW'(LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || expired) begin
      count <= '0;
    end else if (run) begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/word_assembler.sv
// Packs a byte stream into N_BYTES-wide words with a one-word output buffer.
// Ports: in_data/in_data_ready, flush, clr_overflow, out_* handshake, status.
module word_assembler
  import word_asm_pkg::*;
#(
  parameter int N_BYTES        = 4,
  parameter int MSB_FIRST      = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               in_data,
  input  logic                     in_data_ready,
  input  logic                     flush,
  input  logic                     clr_overflow,
  output logic [8*N_BYTES-1:0]     out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(N_BYTES):0] byte_count,
  output logic                     overflow,
  output logic                     frame_err
);

  localparam int CW = count_width(N_BYTES);
  localparam int W  = 8 * N_BYTES;

  state_t        state;
  state_t        state_nx;
  logic [W-1:0]  asm_q;
  logic [W-1:0]  asm_nx;
  logic [CW-1:0] lane;
  logic          accept;
  logic          last;
  logic          load;
  logic          drop;
  logic          tmr_run;
  logic          tmr_clear;
  logic          expired;

  // flush wins over a byte in the same cycle
  assign accept = in_data_ready && !flush;
  assign last   = accept &&
                  (byte_count == CW'(N_BYTES - 1));
  // a full buffer being drained this cycle can still take the word
  assign load   = last && (!out_valid || out_ready);
  assign drop   = last && out_valid && !out_ready;

  assign tmr_run   = (state == COLLECT) &&
                     !in_data_ready && !flush;
  assign tmr_clear = accept || flush || (state == IDLE);

  assign lane = (MSB_FIRST != 0)
              ? CW'(N_BYTES - 1) - byte_count
              : byte_count;

  always_comb begin
    asm_nx = asm_q;
    for (int i = 0; i < N_BYTES; i++) begin
      if (lane == CW'(i)) begin
        asm_nx[8*i +: 8] = in_data;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = COLLECT;
      end
      COLLECT: begin
        if (flush || expired || last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  word_asm_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .run    (tmr_run),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_count <= '0;
      asm_q      <= '0;
    end else begin
      state <= state_nx;
      if (flush || expired || last) begin
        byte_count <= '0;
        asm_q      <= '0;
      end else if (accept) begin
        byte_count <= byte_count + CW'(1);
        asm_q      <= asm_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= asm_nx;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= expired;
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_word_assembler.sv
// Scoreboard bench for word_assembler (MSB-first w/ timeout, LSB-first).
// Expected words are queued at stimulus time and popped on handshake.
module tb_word_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        rdy_a;
  logic        rdy_b;
  logic        flush;
  logic        clr;
  logic        out_ready;

  logic [31:0] a_data;
  logic        a_valid;
  logic [2:0]  a_cnt;
  logic        a_ovf;
  logic        a_ferr;
  logic [31:0] b_data;
  logic        b_valid;
  logic [2:0]  b_cnt;
  logic        b_ovf;
  logic        b_ferr;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  word_assembler #(
    .N_BYTES(4), .MSB_FIRST(1), .TIMEOUT_CYCLES(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_data_ready(rdy_a),
    .flush(flush), .clr_overflow(clr),
    .out_data(a_data), .out_valid(a_valid),
    .out_ready(out_ready), .byte_count(a_cnt),
    .overflow(a_ovf), .frame_err(a_ferr)
  );

  word_assembler #(
    .N_BYTES(4), .MSB_FIRST(0), .TIMEOUT_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_data_ready(rdy_b),
    .flush(flush), .clr_overflow(clr),
    .out_data(b_data), .out_valid(b_valid),
    .out_ready(out_ready), .byte_count(b_cnt),
    .overflow(b_ovf), .frame_err(b_ferr)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] b);
    in_data = b;
    rdy_a   = 1'b1;
    tick();
    rdy_a   = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    in_data = b;
    rdy_b   = 1'b1;
    tick();
    rdy_b   = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && a_valid && out_ready) begin
      chk("a_pending", 64'(qa.size() != 0), 1);
      if (qa.size() != 0) chk("a_word", a_data, qa.pop_front());
    end
    if (rst_n && b_valid && out_ready) begin
      chk("b_pending", 64'(qb.size() != 0), 1);
      if (qb.size() != 0) chk("b_word", b_data, qb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_data = '0; rdy_a = 1'b0; rdy_b = 1'b0;
    flush = 1'b0; clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", a_valid, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_data", a_data, 0);
    chk("rst_ovf", a_ovf, 0);
    rst_n = 1'b1;
    tick();

    // MSB-first basic word, one-cycle valid pulse
    qa.push_back(32'h12345678);
    send_a(8'h12); send_a(8'h34); send_a(8'h56); send_a(8'h78);
    @(negedge clk);
    chk("s1_valid", a_valid, 1);
    chk("s1_data", a_data, 32'h12345678);
    @(negedge clk);
    chk("s1_valid_fall", a_valid, 0);
    chk("s1_data_hold", a_data, 32'h12345678);
    tick();

    // LSB-first
    qb.push_back(32'h78563412);
    send_b(8'h12); send_b(8'h34); send_b(8'h56); send_b(8'h78);
    @(negedge clk);
    chk("s2_valid", b_valid, 1);
    chk("s2_data", b_data, 32'h78563412);
    tick();

    // backpressure: second word dropped
    out_ready = 1'b0;
    qa.push_back(32'h01020304);
    for (int i = 1; i <= 8; i++) send_a(8'(i));
    @(negedge clk);
    chk("s3_ovf", a_ovf, 1);
    chk("s3_valid", a_valid, 1);
    chk("s3_data", a_data, 32'h01020304);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    @(negedge clk);
    chk("s3_ovf_clr", a_ovf, 0);
    chk("s3_valid_held", a_valid, 1);
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("s3_drained", a_valid, 0);
    tick();

    // timeout after 16 idle cycles
    send_a(8'hAA); send_a(8'hBB);
    @(negedge clk);
    chk("s4_cnt2", a_cnt, 2);
    repeat (15) tick();
    chk("s4_ferr_early", a_ferr, 0);
    chk("s4_cnt_early", a_cnt, 2);
    tick();
    chk("s4_ferr", a_ferr, 1);
    chk("s4_cnt0", a_cnt, 0);
    tick();
    chk("s4_ferr_pulse", a_ferr, 0);
    qa.push_back(32'h11223344);
    send_a(8'h11); send_a(8'h22); send_a(8'h33); send_a(8'h44);
    @(negedge clk);
    chk("s4_data", a_data, 32'h11223344);
    tick();

    // byte on the would-expire cycle is accepted
    send_a(8'hAA);
    repeat (15) tick();
    send_a(8'hBB);
    chk("s4b_ferr", a_ferr, 0);
    chk("s4b_cnt", a_cnt, 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("s4b_flush", a_cnt, 0);

    // async reset mid-word
    send_a(8'h01); send_a(8'h02);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_data", a_data, 0);
    chk("s5_valid", a_valid, 0);
    chk("s5_cnt", a_cnt, 0);
    chk("s5_ovf", a_ovf, 0);
    chk("s5_ferr", a_ferr, 0);
    chk("s5_bdata", b_data, 0);
    tick();
    rst_n = 1'b1;
    qa.push_back(32'hCAFEBABE);
    send_a(8'hCA); send_a(8'hFE); send_a(8'hBA); send_a(8'hBE);
    @(negedge clk);
    chk("s5_word", a_data, 32'hCAFEBABE);
    tick();

    // flush together with the third byte
    send_a(8'h01); send_a(8'h02);
    in_data = 8'h03; rdy_a = 1'b1; flush = 1'b1;
    tick();
    rdy_a = 1'b0; flush = 1'b0;
    chk("s6_cnt", a_cnt, 0);
    qa.push_back(32'hA1B2C3D4);
    send_a(8'hA1); send_a(8'hB2); send_a(8'hC3); send_a(8'hD4);
    @(negedge clk);
    chk("s6_data", a_data, 32'hA1B2C3D4);
    chk("s6_ovf", a_ovf, 0);

    repeat (4) tick();
    chk("qa_empty", 64'(qa.size()), 0);
    chk("qb_empty", 64'(qb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/word_assembler.md
WORD_ASSEMBLER -- requirements
Module: word_assembler

Interface
REQ-001 The block SHALL have parameter N_BYTES, default 4, meaning bytes per output word (legal values 2..8).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, meaning the first received byte lands in the top byte lane (1) or in the bottom byte lane [7:0] (0).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 0, meaning the idle cycles allowed inside a partial word; 0 disables the timeout.
REQ-004 The block SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-006 The block SHALL have port in_data  input  8  meaning the received byte.
REQ-007 The block SHALL have port in_data_ready  input  1  meaning in_data is valid this cycle; there is no input backpressure.
REQ-008 The block SHALL have port flush  input  1  meaning a synchronous discard of the partial word.
REQ-009 The block SHALL have port clr_overflow  input  1  meaning a synchronous clear of the overflow flag.
REQ-010 The block SHALL have port out_data  output  8*N_BYTES  meaning the assembled word.
REQ-011 The block SHALL have port out_valid  output  1  meaning out_data holds an undelivered word.
REQ-012 The block SHALL have port out_ready  input  1  meaning the consumer accepts out_data when out_valid and out_ready are both 1.
REQ-013 The block SHALL have port byte_count  output  clog2(N_BYTES)+1  meaning the number of bytes held in the partial word.
REQ-014 The block SHALL have port overflow  output  1  meaning a sticky flag that a completed word was dropped.
REQ-015 The block SHALL have port frame_err  output  1  meaning a one-cycle pulse that a partial word was discarded by timeout.

Function
REQ-016 The FSM SHALL have two states: IDLE (byte_count=0) and COLLECT (0<byte_count<N_BYTES).
- IDLE -> COLLECT: on an accepted byte.
- COLLECT -> IDLE: on the N_BYTES-th byte, on flush, or on timeout.
REQ-017 Each cycle with in_data_ready=1 SHALL write in_data into lane k of the assembly register and increment byte_count.
- k = byte_count when MSB_FIRST=0.
- k = N_BYTES-1-byte_count when MSB_FIRST=1.
REQ-018 On the N_BYTES-th byte, the full word (including that byte) SHALL load into out_data, out_valid SHALL be 1 from the next cycle (latency 1), and byte_count SHALL return to 0.
REQ-019 out_valid SHALL remain 1 and out_data SHALL remain stable until a cycle with out_ready=1; out_valid then falls the next cycle unless a new word loads in that same cycle.
REQ-020 When a word completes while out_valid=1 and out_ready=1 in the same cycle, the new word SHALL load and out_valid SHALL stay 1 with no bubble.
REQ-021 When a word completes while out_valid=1 and out_ready=0, the new word SHALL be dropped, out_data SHALL be unchanged, and overflow SHALL be set.
REQ-022 overflow SHALL stay set until the cycle after clr_overflow=1; when a drop and clr_overflow occur in the same cycle, set SHALL win.
REQ-023 The idle timer SHALL count cycles in COLLECT with in_data_ready=0 and SHALL clear on every accepted byte and on entry to IDLE.
REQ-024 When the idle timer reaches TIMEOUT_CYCLES, the partial word SHALL be discarded, byte_count SHALL become 0, and frame_err SHALL pulse for 1 cycle.
REQ-025 A byte arriving in the cycle the idle timer would expire SHALL be accepted, and no timeout SHALL occur.
REQ-026 When flush=1, byte_count SHALL become 0 and any byte in the same cycle SHALL be discarded; flush SHALL NOT affect out_data, out_valid, overflow, or frame_err.
REQ-027 out_data SHALL hold its last value after the word is taken; unused lanes are never partially updated.

Reset
REQ-028 When rst_n=0, the block SHALL immediately clear out_data, out_valid, byte_count, overflow, frame_err, the idle timer and the assembly register to 0, and enter IDLE.
REQ-029 Asserting reset mid-word SHALL discard the partial word; the first byte after release SHALL be treated as byte 0.

Structure
REQ-030 The shared package word_asm_pkg SHALL hold the FSM state type and the byte_count/timer width helper functions.
REQ-031 The idle timer SHALL be the sub-module word_asm_timeout (ports: clk, rst_n, clear, run, expired; parameter TIMEOUT_CYCLES).

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- N_BYTES=4, MSB_FIRST=1, out_ready=1, bytes 12,34,56,78 -> out_data=0x12345678, out_valid high 1 cycle, starting the cycle after byte 78.
- MSB_FIRST=0, same bytes -> out_data=0x78563412.
- out_ready=0, bytes 01..08 -> out_data=0x01020304 held, overflow=1; then clr_overflow -> overflow=0.
- TIMEOUT_CYCLES=16, bytes AA,BB then 16 idle cycles -> frame_err pulse, byte_count=0; then 11,22,33,44 -> 0x11223344.
- rst_n low after 2 bytes -> all outputs 0; then CA,FE,BA,BE -> 0xCAFEBABE.
- flush together with the 3rd byte -> byte_count=0; the next 4 bytes give a correct word; overflow=0.
